// File: rtl/conv_pixel_feeder.sv
// Streams one stored feature map from a synchronous-read frame buffer into a line-buffer
// conv engine in raster order, appends zero flush pixels, and counts the engine's results.
module conv_pixel_feeder #(
    parameter int IMG_Width   = 5,
    parameter int IMG_Height  = 5,
    parameter int Datawidth   = 16,
    parameter int Addr_Width  = 10,
    parameter int Flush_Count = 2 * IMG_Width + 2,
    parameter int Stride      = 1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  Start,
    input  logic [Addr_Width-1:0] Base_Addr,
    input  logic                  Hold,
    output logic                  Mem_RdEn,
    output logic [Addr_Width-1:0] Mem_Addr,
    input  logic [Datawidth-1:0]  Mem_Data,
    output logic [Datawidth-1:0]  Out,
    output logic                  Valid_OUT,
    input  logic                  Result_Valid,
    output logic [15:0]           Result_Count,
    output logic                  Busy,
    output logic                  Done
);
    localparam int N  = IMG_Width * IMG_Height;
    localparam int E  = ((IMG_Width + Stride - 1) / Stride) * ((IMG_Height + Stride - 1) / Stride);
    localparam int IW = $clog2(N + 1);
    localparam int FW = $clog2(Flush_Count + 2);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(Flush_Count);
    localparam logic [15:0]   E_CNT      = 16'(E);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_WAIT_OUT, S_DONE} state_t;

    state_t                state_q;
    logic [Addr_Width-1:0] base_q;
    logic [Addr_Width-1:0] mem_addr_q;
    logic [IW-1:0]         idx_q;
    logic [FW-1:0]         flush_q;
    logic                  mem_rden_q;
    logic                  rd_pending_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic [Datawidth-1:0]  out_q;
    logic [15:0]           rcount_q;
    logic [15:0]           rcount_d;
    logic                  counting;
    logic                  pipe_empty;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign counting   = (state_q == S_READ) || (state_q == S_FLUSH) || (state_q == S_WAIT_OUT);
    assign rcount_d   = (counting && Result_Valid) ? sat_inc(rcount_q) : rcount_q;
    // A zero may only follow once no real pixel is still travelling through the RAM pipe.
    assign pipe_empty = !mem_rden_q && !rd_pending_q;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            mem_addr_q   <= '0;
            idx_q        <= '0;
            flush_q      <= '0;
            mem_rden_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_q        <= '0;
            rcount_q     <= '0;
        end else begin
            rd_pending_q <= mem_rden_q;
            mem_rden_q   <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            if (rd_pending_q) begin
                out_q   <= Mem_Data;
                valid_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        base_q   <= Base_Addr;
                        idx_q    <= '0;
                        rcount_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    rcount_q <= rcount_d;
                    if (!Hold) begin
                        mem_rden_q <= 1'b1;
                        mem_addr_q <= base_q + Addr_Width'(idx_q);
                        idx_q      <= idx_q + IW'(1);
                        if (idx_q == LAST_IDX) begin
                            flush_q <= FLUSH_INIT;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    rcount_q <= rcount_d;
                    if (flush_q == '0) begin
                        if (pipe_empty) state_q <= S_WAIT_OUT;
                    end else if (pipe_empty && !Hold) begin
                        out_q   <= '0;
                        valid_q <= 1'b1;
                        flush_q <= flush_q - FW'(1);
                        if (flush_q == FW'(1)) state_q <= S_WAIT_OUT;
                    end
                end
                S_WAIT_OUT: begin
                    rcount_q <= rcount_d;
                    // The strobe that reaches E in this cycle is already folded into rcount_d.
                    if (rcount_d >= E_CNT) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Mem_RdEn     = mem_rden_q;
    assign Mem_Addr     = mem_addr_q;
    assign Out          = out_q;
    assign Valid_OUT    = valid_q;
    assign Result_Count = rcount_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Bench for conv_pixel_feeder: a stride-1 and a stride-2 instance share one frame buffer;
// streams, addresses and completion are compared against a stream-level model.
module tb_conv_pixel_feeder;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int FC = 2 * W + 2;
    localparam int N  = W * H;
    localparam int E1 = 25;
    localparam int E2 = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, hold, rv1, rv2;
    logic [AW-1:0] base_addr;
    logic          rden1, rden2, vo1, vo2, busy1, busy2, done1, done2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] mdata1 = '0;
    logic [DW-1:0] mdata2 = '0;
    logic [DW-1:0] out1, out2;
    logic [15:0]   rc1, rc2;
    logic [DW-1:0] ram [0:1023];

    always @(posedge clk) begin
        if (rden1) mdata1 <= ram[addr1];
        if (rden2) mdata2 <= ram[addr2];
    end

    conv_pixel_feeder #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW), .Addr_Width(AW),
                        .Flush_Count(FC), .Stride(1)) u_dut (
        .CLK(clk), .CLR(rst), .Start(start), .Base_Addr(base_addr), .Hold(hold),
        .Mem_RdEn(rden1), .Mem_Addr(addr1), .Mem_Data(mdata1), .Out(out1), .Valid_OUT(vo1),
        .Result_Valid(rv1), .Result_Count(rc1), .Busy(busy1), .Done(done1));

    conv_pixel_feeder #(.IMG_Width(W), .IMG_Height(H), .Datawidth(DW), .Addr_Width(AW),
                        .Flush_Count(FC), .Stride(2)) u_dut_s2 (
        .CLK(clk), .CLR(rst), .Start(start), .Base_Addr(base_addr), .Hold(hold),
        .Mem_RdEn(rden2), .Mem_Addr(addr2), .Mem_Data(mdata2), .Out(out2), .Valid_OUT(vo2),
        .Result_Valid(rv2), .Result_Count(rc2), .Busy(busy2), .Done(done2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int rnd;
        int hold_at;
        int hold_len;
        int fhold_at;
        int fhold_len;
        int restart_at;
        int start_on_done;
        int exp_pulses;
        int exp_zeros;
        int exp_gap;
    } vec_t;

    vec_t vecs [8];

    task automatic run_frame(input int vi);
        vec_t v;
        logic [DW-1:0] got[$];
        logic [AW-1:0] addrs[$];
        int pulses = 0, zeros = 0, owed = 0, rv_sent = 0, post = 0;
        int done_n = 0, done2_n = 0, done_cyc = -1, done2_cyc = -1;
        int last_rv = -2, last_rv2 = -2, first_rd = -1, first_vo = -1, prev_vo = 0;
        int max_gap = 0, hold_left = 0, bad = 0;
        bit rheld = 0, fheld = 0;
        logic [DW-1:0] exp_px;
        v = vecs[vi];
        for (int i = 0; i < N; i++)
            ram[(v.base + i) % 1024] = (v.rnd != 0) ? DW'($urandom) : DW'(i + 1);

        start = 1; base_addr = AW'(v.base); hold = 0; rv1 = 0; rv2 = 0;
        for (int cyc = 0; cyc < 600 && post < 4; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            if (cyc == 0) begin
                check($sformatf("v%0d busy after start", vi), busy1, 1);
                check($sformatf("v%0d count cleared", vi), rc1, 0);
            end
            if (rden1) begin
                addrs.push_back(addr1);
                if (first_rd < 0) first_rd = cyc;
            end
            if (vo1) begin
                got.push_back(out1);
                pulses++;
                if (first_vo < 0) first_vo = cyc;
                else if (cyc - prev_vo - 1 > max_gap) max_gap = cyc - prev_vo - 1;
                prev_vo = cyc;
                if (pulses > N && out1 == '0) zeros++;
                if (pulses > FC) owed++;
            end
            if (done1) begin
                done_n++; done_cyc = cyc;
                check($sformatf("v%0d busy falls with done", vi), busy1, 0);
            end
            if (done2) begin done2_n++; done2_cyc = cyc; end
            if (done_n > 0) post++;

            if (v.restart_at == cyc) begin start = 1; base_addr = AW'(v.base + 50); end
            if (done1 && v.start_on_done != 0) start = 1;

            hold = 0;
            if (v.rnd != 0) hold = ($urandom_range(0, 3) == 0);
            else if (hold_left > 0) begin hold = 1; hold_left--; end
            else if (!rheld && v.hold_at >= 0 && rden1 && addrs.size() == v.hold_at) begin
                rheld = 1; hold = 1; hold_left = v.hold_len - 1;
            end else if (!fheld && v.fhold_at >= 0 && vo1 && pulses > N && zeros == v.fhold_at) begin
                fheld = 1; hold = 1; hold_left = v.fhold_len - 1;
            end

            rv1 = 0; rv2 = 0;
            if (owed > 0 && (v.rnd == 0 || $urandom_range(0, 1) == 1)) begin
                rv1 = 1; owed--; rv_sent++; last_rv = cyc;
                if (rv_sent > E1 - E2) begin rv2 = 1; last_rv2 = cyc; end
            end
        end
        start = 0; hold = 0; rv1 = 0; rv2 = 0;

        check($sformatf("v%0d read count", vi), addrs.size(), N);
        bad = 0;
        foreach (addrs[i]) if (addrs[i] !== AW'(v.base + i)) bad++;
        check($sformatf("v%0d address mismatches", vi), bad, 0);
        check($sformatf("v%0d valid pulses", vi), pulses, v.exp_pulses);
        check($sformatf("v%0d flush zeros", vi), zeros, v.exp_zeros);
        bad = 0;
        foreach (got[i]) begin
            exp_px = (i < N) ? ram[(v.base + i) % 1024] : '0;
            if (got[i] !== exp_px) bad++;
        end
        check($sformatf("v%0d pixel mismatches", vi), bad, 0);
        check($sformatf("v%0d read-to-pixel latency", vi), first_vo - first_rd, 2);
        if (v.exp_gap >= 0) check($sformatf("v%0d max valid gap", vi), max_gap, v.exp_gap);
        check($sformatf("v%0d done pulses", vi), done_n, 1);
        check($sformatf("v%0d done timing", vi), done_cyc, last_rv + 1);
        check($sformatf("v%0d result count", vi), rc1, E1);
        check($sformatf("v%0d busy idle", vi), busy1, 0);
        check($sformatf("v%0d s2 done pulses", vi), done2_n, 1);
        check($sformatf("v%0d s2 done timing", vi), done2_cyc, last_rv2 + 1);
        check($sformatf("v%0d s2 result count", vi), rc2, E2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rden"}, rden1, 0);
        check({tag, " addr"}, addr1, 0);
        check({tag, " out"}, out1, 0);
        check({tag, " valid"}, vo1, 0);
        check({tag, " count"}, rc1, 0);
        check({tag, " busy"}, busy1, 0);
        check({tag, " done"}, done1, 0);
    endtask

    initial begin
        int issued, dn;
        //           base rnd hold_at len fhold_at len restart sod pulses zeros gap
        vecs[0] = '{100, 0, -1, 0, -1, 0, -1, 1, 37, 12, 0};
        vecs[1] = '{100, 0,  7, 3, -1, 0, -1, 0, 37, 12, 3};
        vecs[2] = '{100, 0, -1, 0,  4, 5, -1, 0, 37, 12, 5};
        vecs[3] = '{1015, 0, -1, 0, -1, 0, 10, 0, 37, 12, 0};
        for (int i = 4; i < 8; i++)
            vecs[i] = '{int'($urandom_range(0, 1023)), 1, -1, 0, -1, 0, -1, 0, 37, 12, -1};

        rst = 1; start = 0; hold = 0; rv1 = 0; rv2 = 0; base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;
        @(posedge clk); #1;

        for (int vi = 0; vi < 8; vi++) run_frame(vi);

        // Abort a frame with CLR after ten reads have been issued.
        for (int i = 0; i < N; i++) ram[200 + i] = DW'(i + 1);
        issued = 0; dn = 0;
        start = 1; base_addr = AW'(200);
        for (int cyc = 0; cyc < 100 && issued < 10; cyc++) begin
            @(posedge clk); #1;
            start = 0;
            if (rden1) issued++;
            if (done1) dn++;
        end
        check("clr reached pixel 10", issued, 10);
        #2 rst = 1;
        #1;
        check_reset_outputs("async clr");
        repeat (2) begin
            @(posedge clk); #1;
            if (done1) dn++;
        end
        check("clr no done", dn, 0);
        check("clr s2 busy", busy2, 0);
        rst = 0;
        @(posedge clk); #1;
        check("post clr count", rc1, 0);
        run_frame(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_pixel_feeder.md
Name: conv_pixel_feeder

Overview:
- Streams one stored feature map from a synchronous-read frame buffer into a 2D convolution engine (3x3 or 5x5 line-buffer style) in raster order.
- After the last real pixel it appends zero-valued flush pixels, so the engine's line buffer drains the final rows.
- It counts the engine's result strobes and reports completion.
- It sits between the frame-buffer RAM and the conv engine's In/Valid_IN port, and is started by the layer controller.

Parameters:
- IMG_Width, 5, pixels per row
- IMG_Height, 5, rows per frame
- Datawidth, 16, pixel width (two's complement)
- Addr_Width, 10, frame-buffer address width
- Flush_Count, 2*IMG_Width+2, zero pixels appended after the frame (2*IMG_Width+2 for 5x5, IMG_Width+1 for 3x3)
- Stride, 1, engine stride, used only to compute the expected result count

Ports:
- CLK  in  1  clock
- CLR  in  1  asynchronous active-high reset
- Start  in  1  one-cycle pulse; begin a frame (honoured in IDLE only)
- Base_Addr  in  Addr_Width  frame start address, latched on accepted Start
- Hold  in  1  stall: no new read issued and no flush pixel emitted while high
- Mem_RdEn  out  1  frame-buffer read enable
- Mem_Addr  out  Addr_Width  read address
- Mem_Data  in  Datawidth  read data, valid the cycle after Mem_RdEn
- Out  out  Datawidth  pixel to engine In
- Valid_OUT  out  1  pixel strobe to engine Valid_IN
- Result_Valid  in  1  engine Valid_OUT strobe
- Result_Count  out  16  results counted this frame
- Busy  out  1  high from accepted Start until Done
- Done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, CLR=1):
  - State IDLE.
  - Mem_RdEn=0, Mem_Addr=0, Out=0, Valid_OUT=0.
  - Result_Count=0, Busy=0, Done=0.
  - Pixel index=0, flush counter=0, rd_pending=0.
- All outputs are registered.
- Expected result count E = ceil(IMG_Width/Stride)*ceil(IMG_Height/Stride).
- N = IMG_Width*IMG_Height.
- IDLE:
  - Start=1 latches Base_Addr, clears index and Result_Count, sets Busy=1, goes to READ.
  - Start in any other state is ignored.
- READ:
  - Each cycle with Hold=0: Mem_RdEn=1, Mem_Addr=Base_Addr+index, index+1.
  - With Hold=1: Mem_RdEn=0 and the index holds.
  - Goes to FLUSH on the cycle after issuing index N-1.
  - Address arithmetic is modulo 2^Addr_Width (wraps silently).
- Read pipeline:
  - rd_pending is Mem_RdEn delayed by one cycle.
  - When rd_pending=1: Out<=Mem_Data and Valid_OUT<=1, regardless of Hold. An in-flight read is never dropped.
  - Latency: a pixel appears on Out/Valid_OUT 2 cycles after its Mem_RdEn.
- FLUSH:
  - Flush counter is loaded with Flush_Count on entry.
  - Each cycle with rd_pending=0 and Hold=0: Out<=0, Valid_OUT<=1, counter-1.
  - rd_pending has priority; the first FLUSH cycle always carries the last real pixel.
  - Counter reaching 0 goes to WAIT_OUT.
  - Flush_Count=0 skips FLUSH, going directly to WAIT_OUT after the last pixel is emitted.
- Valid_OUT is 0 in every cycle no pixel is emitted. Gaps in Valid_OUT are legal (the engine advances only on Valid_IN).
- Result counting:
  - In READ, FLUSH and WAIT_OUT, each Result_Valid=1 cycle increments Result_Count (saturating at 16'hFFFF).
  - Result_Valid in IDLE or DONE is ignored.
- WAIT_OUT: when Result_Count==E, go to DONE.
- DONE:
  - Done=1 for exactly one cycle, Busy<=0, return to IDLE.
  - Result_Count holds its value until the next accepted Start.
- Result_Valid arriving in the same cycle Result_Count reaches E still terminates normally. Extra strobes after E are counted but do not re-trigger Done.
- CLR asserted mid-frame aborts immediately to reset values. No Done is produced.
- Start coinciding with Done (DONE state) is ignored; the controller must re-issue Start.

Test Plan:
- W=H=5, Flush_Count=12, Base_Addr=100, RAM[100+i]=i+1, Hold=0, Start pulse:
  - Mem_Addr 100..124 on consecutive cycles.
  - Out 1..25 starting 2 cycles after the first Mem_RdEn, then 12 zeros contiguous.
  - Exactly 37 Valid_OUT pulses.
- Same frame with a model engine returning 25 Result_Valid strobes:
  - Done pulses once, one cycle after the 25th counted strobe; Result_Count=25; Busy falls with Done.
- Hold=1 for 3 cycles starting at index 7:
  - No RdEn during the hold.
  - Pixel 7 (already issued) still emitted; Valid_OUT shows a 3-cycle gap.
  - Sequence stays 1..25 with no duplicates or drops.
- Hold=1 during FLUSH after 4 zeros emitted: zeros pause, then 8 more follow when Hold falls; total zeros = 12.
- Stride=2, W=H=5: E=9; Done after the 9th Result_Valid. Start pulsed while Busy is ignored (no address restart).
- CLR asserted at pixel 10, then released and Start reissued:
  - All outputs zero during reset; no Done from the aborted frame.
  - New frame restarts at Base_Addr with Result_Count=0.
